// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states, ALU
// operation codes, opcode constants and datapath mux-select codes.
package rv_multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_ALU   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_TRAP     = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Which rule the ALU decoder applies to the latched funct fields.
  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_SUB = 2'd1,
    CLS_R   = 2'd2,
    CLS_I   = 2'd3
  } alu_cls_e;

  typedef enum logic [1:0] {WB_ALUOUT = 2'd0, WB_MDR  = 2'd1, WB_PC  = 2'd2} wb_sel_e;
  typedef enum logic [1:0] {A_PC      = 2'd0, A_OLDPC = 2'd1, A_RD1  = 2'd2} alu_a_e;
  typedef enum logic [1:0] {B_RD2     = 2'd0, B_FOUR  = 2'd1, B_IMM  = 2'd2} alu_b_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/rv_multicycle_ctrl_alu_decoder.sv
// Combinational ALU-operation decode from the operation class and the
// latched funct3/funct7b5 fields of the current instruction.
module rv_multicycle_ctrl_alu_decoder
  import rv_multicycle_ctrl_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output alu_op_e    alu_op_o
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    alu_op_o = ALU_ADD;
    case (cls_i)
      CLS_SUB: alu_op_o = ALU_SUB;
      CLS_R, CLS_I: begin
        case (funct3_i)
          3'b000: alu_op_o = (cls_i == CLS_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op_o = ALU_SLL;
          3'b010: alu_op_o = ALU_SLT;
          3'b011: alu_op_o = ALU_SLTU;
          3'b100: alu_op_o = ALU_XOR;
          3'b101: alu_op_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110: alu_op_o = ALU_OR;
          default: alu_op_o = ALU_AND;
        endcase
      end
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences PC, IR, register file,
// ALU and data memory through FETCH/DECODE/EXECUTE/MEM/WB.
module rv_multicycle_ctrl
  import rv_multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       pc_src,
  output logic       ir_we,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_a,
  output logic [1:0] alu_b,
  output logic [3:0] alu_op,
  output logic       mem_req,
  output logic       mem_rw,
  output logic       halted,
  output logic [3:0] state_o
);

  localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;
  alu_cls_e      alu_cls;
  alu_op_e       alu_op_dec;

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_R:               state_d = ST_EXEC_R;
          OP_I:               state_d = ST_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = ST_MEM_ADDR;
          OP_BRANCH:          state_d = ST_BRANCH;
          OP_JAL:             state_d = ST_JAL;
          default:            state_d = ST_TRAP;
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
      ST_MEM_ADDR: state_d = (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD, ST_MEM_WR: begin
        // An acknowledge on the last allowed cycle still completes the access.
        if (mem_ready)
          state_d = (state_q == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
        else if (wait_q == WAIT_LAST)
          state_d = ST_TRAP;
        else
          wait_d = wait_q + 1'b1;
      end
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL: state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Moore decode of the state; RST forces everything idle in the same cycle,
  // which also drops an in-flight mem_req immediately.
  always_comb begin
    pc_we   = 1'b0;
    pc_src  = 1'b0;
    ir_we   = 1'b0;
    rf_we   = 1'b0;
    wb_sel  = WB_ALUOUT;
    alu_a   = A_PC;
    alu_b   = B_RD2;
    alu_cls = CLS_ADD;
    mem_req = 1'b0;
    mem_rw  = 1'b0;
    halted  = 1'b0;
    if (!RST) begin
      case (state_q)
        ST_FETCH: begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          alu_b = B_FOUR;
        end
        ST_DECODE: begin
          alu_a = A_OLDPC;
          alu_b = B_IMM;
        end
        ST_EXEC_R: begin
          alu_a   = A_RD1;
          alu_cls = CLS_R;
        end
        ST_EXEC_I: begin
          alu_a   = A_RD1;
          alu_b   = B_IMM;
          alu_cls = CLS_I;
        end
        ST_MEM_ADDR: begin
          alu_a = A_RD1;
          alu_b = B_IMM;
        end
        ST_MEM_RD: mem_req = 1'b1;
        ST_MEM_WR: begin
          mem_req = 1'b1;
          mem_rw  = 1'b1;
        end
        ST_WB_ALU: rf_we = 1'b1;
        ST_WB_MEM: begin
          rf_we  = 1'b1;
          wb_sel = WB_MDR;
        end
        ST_BRANCH: begin
          alu_a   = A_RD1;
          alu_cls = CLS_SUB;
          pc_we   = br_taken;
          pc_src  = br_taken;
        end
        ST_JAL: begin
          rf_we  = 1'b1;
          wb_sel = WB_PC;
          pc_we  = 1'b1;
          pc_src = 1'b1;
        end
        ST_TRAP: halted = 1'b1;
        default: halted = 1'b1;
      endcase
    end
  end

  rv_multicycle_ctrl_alu_decoder u_alu_dec (
    .cls_i      (alu_cls),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .alu_op_o   (alu_op_dec)
  );

  assign alu_op  = alu_op_dec;
  assign state_o = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench: per-cycle expected control words are queued by the
// stimulus process and compared by an independent negedge monitor.
module tb_rv_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, br_taken, mem_ready;
  logic       pc_we, pc_src, ir_we, rf_we, mem_req, mem_rw, halted;
  logic [1:0] wb_sel, alu_a, alu_b;
  logic [3:0] alu_op, state_o;

  rv_multicycle_ctrl dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .br_taken(br_taken), .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src),
    .ir_we(ir_we), .rf_we(rf_we), .wb_sel(wb_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .mem_req(mem_req), .mem_rw(mem_rw), .halted(halted),
    .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    bit         pc_we, pc_src, ir_we, rf_we, mem_req, mem_rw, halted, alu_care;
    logic [1:0] wb_sel, alu_a, alu_b;
    logic [3:0] alu_op;
  } exp_t;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;
  localparam int NEVER = 99;

  exp_t exp_q[$];
  exp_t cyc_q[$];
  bit   rdy_q[$];
  bit   rst_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference ALU rule: base op by funct3, IR[30] selects SUB (R-type only) or SRA.
  function automatic logic [3:0] ref_alu(bit is_r, logic [2:0] f3, logic f7);
    logic [3:0] base [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (f3 == 3'd5 && f7) return 4'd7;
    if (f3 == 3'd0 && f7 && is_r) return 4'd1;
    return base[f3];
  endfunction

  function automatic exp_t idle(string tag);
    exp_t e;
    e.tag = tag;
    e.pc_we = 0; e.pc_src = 0; e.ir_we = 0; e.rf_we = 0;
    e.mem_req = 0; e.mem_rw = 0; e.halted = 0; e.alu_care = 0;
    e.wb_sel = 0; e.alu_a = 0; e.alu_b = 0; e.alu_op = 0;
    return e;
  endfunction

  function automatic exp_t alu_phase(string tag, int a, int b, logic [3:0] op);
    exp_t e = idle(tag);
    e.alu_care = 1; e.alu_a = 2'(a); e.alu_b = 2'(b); e.alu_op = op;
    return e;
  endfunction

  task automatic add(input exp_t e, input bit rdy, input bit rst);
    cyc_q.push_back(e);
    rdy_q.push_back(rdy);
    rst_q.push_back(rst);
  endtask

  // Publish the whole sequence to the scoreboard, then drive it one cycle at a time.
  task automatic run_seq();
    foreach (cyc_q[i]) exp_q.push_back(cyc_q[i]);
    for (int i = 0; i < cyc_q.size(); i++) begin
      mem_ready = rdy_q[i];
      RST       = rst_q[i];
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    mem_ready = 1'b0;
    cyc_q.delete(); rdy_q.delete(); rst_q.delete();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) add(idle("reset"), 1'($urandom), 1'b1);
    run_seq();
  endtask

  // w = extra wait cycles before mem_ready (NEVER -> timeout trap).
  task automatic do_instr(input int kind, input logic [2:0] f3, input bit f7,
                          input int w, input bit taken);
    exp_t e;
    bit   trapped = 0;
    logic [6:0] op;
    case (kind)
      K_R:   op = 7'h33;
      K_I:   op = 7'h13;
      K_LD:  op = 7'h03;
      K_ST:  op = 7'h23;
      K_BR:  op = 7'h63;
      K_JAL: op = 7'h6F;
      default: begin
        op = 7'(  $urandom);
        while (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 ||
               op == 7'h63 || op == 7'h6F) op = 7'($urandom);
      end
    endcase
    opcode = op; funct3 = f3; funct7b5 = f7;
    br_taken = (kind == K_BR) ? taken : 1'($urandom);

    e = alu_phase("FETCH", 0, 1, 4'd0); e.pc_we = 1; e.ir_we = 1;
    add(e, 1'($urandom), 0);
    add(alu_phase("DECODE", 1, 2, 4'd0), 1'($urandom), 0);
    case (kind)
      K_R, K_I: begin
        add(alu_phase(kind == K_R ? "EXEC_R" : "EXEC_I", 2, kind == K_R ? 0 : 2,
                      ref_alu(kind == K_R, f3, f7)), 1'($urandom), 0);
        e = idle("WB_ALU"); e.rf_we = 1; e.wb_sel = 0;
        add(e, 1'($urandom), 0);
      end
      K_LD, K_ST: begin
        add(alu_phase("MEM_ADDR", 2, 2, 4'd0), 1'($urandom), 0);
        for (int j = 0; j < 16; j++) begin
          e = idle(kind == K_LD ? "MEM_RD" : "MEM_WR");
          e.mem_req = 1; e.mem_rw = (kind == K_ST);
          add(e, j == w, 0);
          if (j == w) break;
        end
        if (w >= 16) trapped = 1;
        else if (kind == K_LD) begin
          e = idle("WB_MEM"); e.rf_we = 1; e.wb_sel = 1;
          add(e, 1'($urandom), 0);
        end
      end
      K_BR: begin
        e = alu_phase("BRANCH", 2, 0, 4'd1); e.pc_we = taken; e.pc_src = taken;
        add(e, 1'($urandom), 0);
      end
      K_JAL: begin
        e = idle("JAL"); e.rf_we = 1; e.wb_sel = 2; e.pc_we = 1; e.pc_src = 1;
        add(e, 1'($urandom), 0);
      end
      default: trapped = 1;
    endcase
    if (trapped) begin
      e = idle("TRAP"); e.halted = 1;
      for (int j = 0; j < 4; j++) add(e, 1'($urandom), 0);
    end
    run_seq();
    if (trapped) do_reset(2);
  endtask

  // Monitor: one comparison per cycle that has a queued expectation.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      bit bad;
      e = exp_q.pop_front();
      bad = (pc_we !== e.pc_we) || (ir_we !== e.ir_we) || (rf_we !== e.rf_we) ||
            (mem_req !== e.mem_req) || (halted !== e.halted) ||
            (e.pc_we && pc_src !== e.pc_src) || (e.rf_we && wb_sel !== e.wb_sel) ||
            (e.mem_req && mem_rw !== e.mem_rw) ||
            (e.alu_care && (alu_a !== e.alu_a || alu_b !== e.alu_b || alu_op !== e.alu_op));
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s @%0t: got pcwe=%0b pcsrc=%0b irwe=%0b rfwe=%0b wb=%0d a=%0d b=%0d op=%0d req=%0b rw=%0b halt=%0b | want pcwe=%0b pcsrc=%0b irwe=%0b rfwe=%0b wb=%0d a=%0d b=%0d op=%0d req=%0b rw=%0b halt=%0b",
                 e.tag, $time, pc_we, pc_src, ir_we, rf_we, wb_sel, alu_a, alu_b, alu_op,
                 mem_req, mem_rw, halted, e.pc_we, e.pc_src, e.ir_we, e.rf_we, e.wb_sel,
                 e.alu_a, e.alu_b, e.alu_op, e.mem_req, e.mem_rw, e.halted);
      end
    end
  end

  initial begin
    RST = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 0; br_taken = 0; mem_ready = 0;
    @(posedge CLK); #1;
    do_reset(3);

    // Directed: add, sub, srai, addi with IR[30]=1, load w=2, store timeout,
    // store acked on the final allowed cycle, branch taken/not, jal, illegal.
    do_instr(K_R, 3'd0, 0, 0, 0);
    do_instr(K_R, 3'd0, 1, 0, 0);
    do_instr(K_I, 3'd5, 1, 0, 0);
    do_instr(K_I, 3'd0, 1, 0, 0);
    do_instr(K_LD, 3'd2, 0, 2, 0);
    do_instr(K_ST, 3'd2, 0, NEVER, 0);
    do_instr(K_ST, 3'd2, 0, 15, 0);
    do_instr(K_LD, 3'd2, 0, 15, 0);
    do_instr(K_BR, 3'd0, 0, 0, 1);
    do_instr(K_BR, 3'd0, 0, 0, 0);
    do_instr(K_JAL, 3'd0, 0, 0, 0);
    do_instr(K_ILL, 3'd0, 0, 0, 0);

    // Reset during a pending load: mem_req must drop in the first RST cycle.
    opcode = 7'h03; funct3 = 3'd2;
    add(alu_phase("FETCH", 0, 1, 4'd0), 0, 0);
    cyc_q[0].pc_we = 1; cyc_q[0].ir_we = 1;
    add(alu_phase("DECODE", 1, 2, 4'd0), 0, 0);
    add(alu_phase("MEM_ADDR", 2, 2, 4'd0), 0, 0);
    begin
      exp_t e = idle("MEM_RD");
      e.mem_req = 1;
      add(e, 0, 0);
    end
    run_seq();
    do_reset(2);
    do_instr(K_R, 3'd7, 0, 0, 0);

    for (int n = 0; n < 120; n++) begin
      int k = $urandom_range(0, 19);
      int kind = (k < 3) ? K_R : (k < 6) ? K_I : (k < 9) ? K_LD : (k < 12) ? K_ST :
                 (k < 15) ? K_BR : (k < 18) ? K_JAL : K_ILL;
      int w = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 15);
      do_instr(kind, 3'($urandom), 1'($urandom), w, 1'($urandom));
    end

    @(negedge CLK); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
